dp_mem_param: RTL and testbench

Parametrised simple-dual-port synchronous RAM: one write port, one read port, single clock. Generalises the fixed 512x8 buffer used by the core with:
- configurable width and depth
- per-lane write mask
- selectable read latency
- defined read-during-write behaviour
- optional post-reset clear sequencer, flagged by o_busy

Used for data/stack memory and FIFO storage throughout the design.

---
 rtl/dp_mem_param.sv | 168 ++++++++++++++++
 tb/tb_dp_mem_param.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_mem_param.sv
// dp_mem_param: parametrised simple-dual-port synchronous RAM, single clock.
//   One write port with per-lane mask, one read port with 1- or 2-cycle
//   latency, selectable same-address read-during-write behaviour, and an
//   optional post-reset clear sequence that zeroes every word.
//
// Ports:
//   i_clk     clock, all state on rising edge
//   i_nrst    asynchronous active-low reset
//   i_we      write enable
//   i_wmask   per-lane write enable (bit n covers i_wdata[n*LANE_W +: LANE_W])
//   i_waddr   write address
//   i_wdata   write data
//   i_re      read enable
//   i_raddr   read address
//   o_rdata   read data, holds last value when no read completes
//   o_rvalid  one-cycle pulse per completed read
//   o_busy    clear sequence in progress; user traffic ignored
module dp_mem_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned LANE_W     = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned RDW_MODE   = 0,
  parameter int unsigned CLR_ON_RST = 1
) (
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  logic                       i_we,
  input  logic [DATA_W/LANE_W-1:0]   i_wmask,
  input  logic [ADDR_W-1:0]          i_waddr,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic                       i_re,
  input  logic [ADDR_W-1:0]          i_raddr,
  output logic [DATA_W-1:0]          o_rdata,
  output logic                       o_rvalid,
  output logic                       o_busy
);

  localparam int unsigned NLANE = DATA_W / LANE_W;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  // Elaboration-time parameter legality checks.
  if (!(RD_LAT == 1 || RD_LAT == 2)) begin : g_bad_rd_lat
    $error("dp_mem_param: RD_LAT must be 1 or 2");
  end
  if ((DATA_W % LANE_W) != 0) begin : g_bad_lane
    $error("dp_mem_param: DATA_W must be a multiple of LANE_W");
  end
  if (RDW_MODE > 1) begin : g_bad_rdw
    $error("dp_mem_param: RDW_MODE must be 0 or 1");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [ADDR_W-1:0]   w_clr_cnt_nxt;
  logic                w_busy;
  logic                w_we;
  logic                w_re;
  logic [DATA_W-1:0]   w_rd_word;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  // Clear sequencer: state register
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state   <= RST_STATE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // Clear sequencer: next state. Leaves CLEAR after writing the last word.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      S_CLEAR: begin
        w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
        if (r_clr_cnt == '1) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_busy = (r_state == S_CLEAR);
  assign o_busy = w_busy;
  assign w_we   = i_we & ~w_busy;
  assign w_re   = i_re & ~w_busy;

  // Storage: clear writes take the port while busy, otherwise masked user writes.
  always_ff @(posedge i_clk) begin
    if (w_busy) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_we) begin
      for (int unsigned n = 0; n < NLANE; n++) begin
        if (i_wmask[n]) begin
          r_mem[i_waddr][n*LANE_W +: LANE_W] <= i_wdata[n*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Read word sampled this edge; write-first mode forwards the masked lanes
  // of a same-address write so the result matches the post-write word.
  always_comb begin
    w_rd_word = r_mem[i_raddr];
    if ((RDW_MODE == 1) && w_we && (i_raddr == i_waddr)) begin
      for (int unsigned n = 0; n < NLANE; n++) begin
        if (i_wmask[n]) begin
          w_rd_word[n*LANE_W +: LANE_W] = i_wdata[n*LANE_W +: LANE_W];
        end
      end
    end
  end

  // First read stage: data register only loads on an accepted read.
  logic              r_v1;
  logic [DATA_W-1:0] r_d1;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
    end else begin
      r_v1 <= w_re;
      if (w_re) begin
        r_d1 <= w_rd_word;
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              r_v2;
    logic [DATA_W-1:0] r_d2;

    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
        r_v2 <= 1'b0;
        r_d2 <= '0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_d2 <= r_d1;
        end
      end
    end

    assign o_rdata  = r_d2;
    assign o_rvalid = r_v2;
  end else begin : g_lat1
    assign o_rdata  = r_d1;
    assign o_rvalid = r_v1;
  end

endmodule

// File: tb/tb_dp_mem_param.sv
module tb_dp_mem_param;

  logic clk = 1'b0;
  logic nrst;

  always #5 clk = ~clk;

  // Shared stimulus for the two 16x16 instances (lane width 8)
  logic        we, re;
  logic [1:0]  wmask;
  logic [3:0]  waddr, raddr;
  logic [15:0] wdata;
  logic [15:0] rd0, rd1;
  logic        rv0, rv1, busy0, busy1;

  // Default-parameter instance (512x8)
  logic        we2, re2;
  logic [0:0]  wmask2;
  logic [8:0]  waddr2, raddr2;
  logic [7:0]  wdata2, rd2;
  logic        rv2, busy2;

  dp_mem_param #(
    .DATA_W(16), .ADDR_W(4), .LANE_W(8), .RD_LAT(2), .RDW_MODE(0), .CLR_ON_RST(1)
  ) u_dut0 (
    .i_clk(clk), .i_nrst(nrst), .i_we(we), .i_wmask(wmask), .i_waddr(waddr),
    .i_wdata(wdata), .i_re(re), .i_raddr(raddr), .o_rdata(rd0), .o_rvalid(rv0),
    .o_busy(busy0)
  );

  dp_mem_param #(
    .DATA_W(16), .ADDR_W(4), .LANE_W(8), .RD_LAT(1), .RDW_MODE(1), .CLR_ON_RST(1)
  ) u_dut1 (
    .i_clk(clk), .i_nrst(nrst), .i_we(we), .i_wmask(wmask), .i_waddr(waddr),
    .i_wdata(wdata), .i_re(re), .i_raddr(raddr), .o_rdata(rd1), .o_rvalid(rv1),
    .o_busy(busy1)
  );

  dp_mem_param u_dut2 (
    .i_clk(clk), .i_nrst(nrst), .i_we(we2), .i_wmask(wmask2), .i_waddr(waddr2),
    .i_wdata(wdata2), .i_re(re2), .i_raddr(raddr2), .o_rdata(rd2), .o_rvalid(rv2),
    .o_busy(busy2)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboards: expected read data pushed at issue, popped on o_rvalid
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [7:0]  q2[$];
  int unsigned n_rv2 = 0;

  always @(negedge clk) begin
    if (rv0) begin
      if (q0.size() == 0) chk("dut0 unexpected rvalid", 1, 0);
      else chk("dut0 rdata", rd0, q0.pop_front());
    end
    if (rv1) begin
      if (q1.size() == 0) chk("dut1 unexpected rvalid", 1, 0);
      else chk("dut1 rdata", rd1, q1.pop_front());
    end
    if (rv2) begin
      n_rv2++;
      if (q2.size() == 0) chk("dut2 unexpected rvalid", 1, 0);
      else chk("dut2 rdata", rd2, q2.pop_front());
    end
  end

  typedef struct packed {
    logic        we;
    logic [1:0]  mask;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        re;
    logic [3:0]  raddr;
    logic [15:0] exp0;   // old-data instance
    logic [15:0] exp1;   // write-first instance
  } vec_t;

  vec_t tbl [15];

  task automatic drive16(input vec_t v);
    we = v.we; wmask = v.mask; waddr = v.waddr; wdata = v.wdata;
    re = v.re; raddr = v.raddr;
    if (v.re) begin
      q0.push_back(v.exp0);
      q1.push_back(v.exp1);
    end
  endtask

  task automatic push_read(input logic [3:0] a, input logic [15:0] e);
    re = 1'b1; raddr = a;
    q0.push_back(e);
    q1.push_back(e);
  endtask

  // Counts busy cycles from the release edge onward; drops 16-bit traffic
  // as soon as the small instances finish clearing.
  task automatic wait_clear(output int unsigned c0, output int unsigned c2);
    c0 = 0; c2 = 0;
    for (int unsigned i = 0; i < 1200; i++) begin
      if (busy0) c0++;
      else begin we = 1'b0; re = 1'b0; end
      if (busy2) c2++;
      if (!busy0 && !busy2) break;
      @(negedge clk);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [7:0]  m8 [512];
  int unsigned c0, c2, n_reads;
  logic [4:0]  v0, v1;

  initial begin
    tbl[0]  = '{1'b1, 2'b11, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 2'b01, 4'd3, 16'hABCD, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd3, 16'h12CD, 16'h12CD};
    tbl[3]  = '{1'b1, 2'b00, 4'd3, 16'hFFFF, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[4]  = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd3, 16'h12CD, 16'h12CD};
    tbl[5]  = '{1'b1, 2'b11, 4'd7, 16'h0055, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[6]  = '{1'b1, 2'b11, 4'd7, 16'h00AA, 1'b1, 4'd7, 16'h0055, 16'h00AA};
    tbl[7]  = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd7, 16'h00AA, 16'h00AA};
    tbl[8]  = '{1'b1, 2'b10, 4'd7, 16'hBB00, 1'b1, 4'd7, 16'h00AA, 16'hBBAA};
    tbl[9]  = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd7, 16'hBBAA, 16'hBBAA};
    tbl[10] = '{1'b1, 2'b11, 4'd5, 16'h1111, 1'b1, 4'd6, 16'h0000, 16'h0000};
    tbl[11] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd5, 16'h1111, 16'h1111};
    tbl[12] = '{1'b1, 2'b11, 4'd0, 16'h0011, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[13] = '{1'b1, 2'b11, 4'd1, 16'h0022, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[14] = '{1'b1, 2'b11, 4'd2, 16'h0033, 1'b0, 4'd0, 16'h0000, 16'h0000};
    for (int unsigned i = 0; i < 512; i++) m8[i] = 8'h00;

    nrst = 1'b0;
    we = 1'b0; re = 1'b0; wmask = 2'b00; waddr = '0; raddr = '0; wdata = '0;
    we2 = 1'b0; re2 = 1'b0; wmask2 = 1'b0; waddr2 = '0; raddr2 = '0; wdata2 = '0;
    repeat (3) @(negedge clk);

    chk("reset rdata0", rd0, 0);
    chk("reset rvalid0", rv0, 0);
    chk("reset busy0", busy0, 1);
    chk("reset busy1", busy1, 1);
    chk("reset busy2", busy2, 1);
    chk("reset rdata2", rd2, 0);

    // Traffic during the clear must be dropped
    we = 1'b1; wmask = 2'b11; waddr = 4'd2; wdata = 16'h00A5;
    re = 1'b1; raddr = 4'd2;
    nrst = 1'b1;
    wait_clear(c0, c2);
    chk("busy cycles 16-deep", c0, 16);
    chk("busy cycles 512-deep", c2, 512);

    for (int unsigned a = 0; a < 16; a++) begin
      @(negedge clk);
      push_read(4'(a), 16'h0000);
    end
    @(negedge clk); re = 1'b0;
    repeat (3) @(negedge clk);

    for (int unsigned i = 0; i < 15; i++) begin
      drive16(tbl[i]);
      @(negedge clk);
    end
    we = 1'b0; re = 1'b0;
    repeat (3) @(negedge clk);

    // Back-to-back reads: pipelined results and latency
    push_read(4'd0, 16'h0011);
    @(negedge clk); v0[0] = rv0; v1[0] = rv1; push_read(4'd1, 16'h0022);
    @(negedge clk); v0[1] = rv0; v1[1] = rv1; push_read(4'd2, 16'h0033);
    @(negedge clk); v0[2] = rv0; v1[2] = rv1; re = 1'b0;
    @(negedge clk); v0[3] = rv0; v1[3] = rv1;
    @(negedge clk); v0[4] = rv0; v1[4] = rv1;
    chk("lat2 rvalid pattern", v0, 5'b01110);
    chk("lat1 rvalid pattern", v1, 5'b00111);
    repeat (3) @(negedge clk);
    chk("lat2 rdata hold", rd0, 16'h0033);
    chk("lat1 rdata hold", rd1, 16'h0033);
    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);

    // Async reset clears the output immediately
    nrst = 1'b0;
    #1;
    chk("async rst rdata0", rd0, 0);
    chk("async rst rdata1", rd1, 0);
    chk("async rst busy0", busy0, 1);
    @(negedge clk); nrst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("mid-clear rdata0", rd0, 0);
    chk("mid-clear rvalid0", rv0, 0);
    chk("mid-clear busy0", busy0, 1);
    @(negedge clk); nrst = 1'b1;
    wait_clear(c0, c2);
    chk("restart busy cycles 16-deep", c0, 16);
    chk("restart busy cycles 512-deep", c2, 512);

    @(negedge clk); push_read(4'd3, 16'h0000);
    @(negedge clk); push_read(4'd7, 16'h0000);
    @(negedge clk); push_read(4'd5, 16'h0000);
    @(negedge clk); re = 1'b0;
    repeat (4) @(negedge clk);

    // Random traffic on the default instance against a reference array
    n_reads = 0;
    n_rv2 = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      we2    = 1'($urandom_range(0, 1));
      wmask2 = 1'($urandom_range(0, 3) != 0);
      waddr2 = ($urandom_range(0, 1) != 0) ? 9'($urandom_range(0, 7)) : 9'($urandom);
      raddr2 = ($urandom_range(0, 1) != 0) ? 9'($urandom_range(0, 7)) : 9'($urandom);
      wdata2 = 8'($urandom);
      re2    = 1'($urandom_range(0, 1));
      if (re2) begin
        q2.push_back(m8[raddr2]);
        n_reads++;
      end
      if (we2 && wmask2[0]) m8[waddr2] = wdata2;
    end
    @(negedge clk); we2 = 1'b0; re2 = 1'b0;
    repeat (4) @(negedge clk);
    chk("dut2 rvalid count", n_rv2, n_reads);
    chk("q2 drained", q2.size(), 0);
    chk("q0 final drained", q0.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
